// File: rtl/intr_pkg.sv
// Shared types and field positions for the interrupt controller.
// No ports; imported by intr_edge_pending and intr_controller.
package intr_pkg;

   // Controller sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   // Priority / running level (0 = base code) and level-stack depth.
   typedef logic [1:0] lvl_t;
   typedef logic [1:0] depth_t;

   // Config word bit positions (intDataIn).
   localparam int CFG_EN0      = 0;
   localparam int CFG_EN1      = 1;
   localparam int CFG_LVL0_LSB = 2;
   localparam int CFG_LVL1_LSB = 4;
   localparam int CFG_GIE      = 15;

   // Status word bit positions (intDataOut).
   localparam int ST_CFG_LSB   = 0;
   localparam int ST_PEND_LSB  = 6;
   localparam int ST_CUR_LSB   = 8;
   localparam int ST_DEPTH_LSB = 10;
   localparam int ST_REQ_BIT   = 12;
   localparam int ST_ERR_BIT   = 13;
   localparam int ST_GIE_BIT   = 15;

   // Stored configuration.
   typedef struct packed {
      logic gie;
      lvl_t lvl1;
      lvl_t lvl0;
      logic en1;
      logic en0;
   } cfg_t;

   // Extract the stored configuration from a config write word.
   function automatic cfg_t decode_cfg(input logic [15:0] word);
      cfg_t c;
      c.en0  = word[CFG_EN0];
      c.en1  = word[CFG_EN1];
      c.lvl0 = word[CFG_LVL0_LSB +: 2];
      c.lvl1 = word[CFG_LVL1_LSB +: 2];
      c.gie  = word[CFG_GIE];
      return c;
   endfunction

endpackage

// File: rtl/intr_edge_pending.sv
// Rising-edge capture of one interrupt request line into a pending flag.
// Ports:
//   clk_i     - system clock
//   rst_i     - synchronous active-high reset
//   line_i    - raw request line
//   clr_i     - clear pending (source acknowledged this cycle)
//   pending_o - captured pending request
module intr_edge_pending
   import intr_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   input  logic clr_i,
   output logic pending_o
);

   logic prev_q, prev_d;
   logic pending_q, pending_d;
   logic rise;

   // A fresh edge beats a simultaneous clear so no request is lost.
   always_comb begin
      prev_d    = line_i;
      rise      = line_i & ~prev_q;
      pending_d = rise | (pending_q & ~clr_i);
   end

   // prev resets high: a line already high out of reset is not an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q    <= 1'b1;
         pending_q <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/intr_controller.sv
// Two-source nested interrupt controller.
// Ports:
//   CLK_i         - system clock
//   Reset_i       - synchronous active-high reset
//   int0_i/int1_i - request lines, rising-edge captured
//   intWrite_i    - config write strobe, intDataIn_i = config word
//   intAck_i      - datapath takes the request this cycle
//   intRet_i      - datapath executed return-from-interrupt
//   int_o         - registered interrupt request
//   intVector_o   - handler address of the latched source while int_o=1
//   intLvl_o      - current running level
//   intDataOut_o  - status word
// Handshake: int_o acts as valid and intAck_i as ready; a request is
// transferred on the edge where both are 1. While int_o=1 the vector and
// latched source never change, and int_o drops on the transfer edge.
module intr_controller
   import intr_pkg::*;
#(
   parameter logic [15:0] VEC0       = 16'h0010,
   parameter logic [15:0] VEC1       = 16'h0020,
   parameter int          NEST_DEPTH = 2
) (
   input  logic        CLK_i,
   input  logic        Reset_i,
   input  logic        int0_i,
   input  logic        int1_i,
   input  logic        intWrite_i,
   input  logic [15:0] intDataIn_i,
   input  logic        intAck_i,
   input  logic        intRet_i,
   output logic        int_o,
   output logic [15:0] intVector_o,
   output logic [1:0]  intLvl_o,
   output logic [15:0] intDataOut_o
);

   localparam depth_t DEPTH_MAX = depth_t'(NEST_DEPTH);

   state_e      state_q, state_d;
   cfg_t        cfg_q, cfg_d;
   lvl_t        cur_q, cur_d;
   depth_t      depth_q, depth_d;
   lvl_t        stack_q [NEST_DEPTH];
   lvl_t        stack_d [NEST_DEPTH];
   logic        src_q, src_d;
   lvl_t        req_lvl_q, req_lvl_d;
   logic        int_q, int_d;
   logic [15:0] vec_q, vec_d;
   logic        err_q, err_d;

   logic pend0, pend1;
   logic clr0, clr1;
   logic elig0, elig1;
   logic win1;

   logic unused_cfg_bits;
   assign unused_cfg_bits = ^intDataIn_i[14:6];

   intr_edge_pending u_edge0 (
      .clk_i     (CLK_i),
      .rst_i     (Reset_i),
      .line_i    (int0_i),
      .clr_i     (clr0),
      .pending_o (pend0)
   );

   intr_edge_pending u_edge1 (
      .clk_i     (CLK_i),
      .rst_i     (Reset_i),
      .line_i    (int1_i),
      .clr_i     (clr1),
      .pending_o (pend1)
   );

   // Eligibility is judged against the level/depth before this edge's pop.
   always_comb begin
      elig0 = cfg_q.en0 & pend0 & (cfg_q.lvl0 > cur_q) & cfg_q.gie & (depth_q < DEPTH_MAX);
      elig1 = cfg_q.en1 & pend1 & (cfg_q.lvl1 > cur_q) & cfg_q.gie & (depth_q < DEPTH_MAX);
      // Source 1 only wins with a strictly higher level; ties go to 0.
      win1  = elig1 & (~elig0 | (cfg_q.lvl1 > cfg_q.lvl0));
   end

   always_comb begin
      state_d   = state_q;
      cfg_d     = intWrite_i ? decode_cfg(intDataIn_i) : cfg_q;
      cur_d     = cur_q;
      depth_d   = depth_q;
      stack_d   = stack_q;
      src_d     = src_q;
      req_lvl_d = req_lvl_q;
      int_d     = int_q;
      vec_d     = vec_q;
      err_d     = err_q;
      clr0      = 1'b0;
      clr1      = 1'b0;

      // Return is processed first so a same-edge ack pushes the popped level.
      if (intRet_i) begin
         if (depth_q != '0) begin
            for (int k = 0; k < NEST_DEPTH; k++) begin
               if (k == int'(depth_q) - 1) cur_d = stack_q[k];
            end
            depth_d = depth_q - 2'd1;
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         ST_REQ: begin
            if (intAck_i) begin
               for (int k = 0; k < NEST_DEPTH; k++) begin
                  if (k == int'(depth_d)) stack_d[k] = cur_d;
               end
               cur_d   = req_lvl_q;
               depth_d = depth_d + 2'd1;
               clr0    = ~src_q;
               clr1    = src_q;
               int_d   = 1'b0;
               vec_d   = '0;
               state_d = ST_ACTIVE;
            end
         end
         default: begin
            if (elig0 | elig1) begin
               state_d   = ST_REQ;
               src_d     = win1;
               req_lvl_d = win1 ? cfg_q.lvl1 : cfg_q.lvl0;
               int_d     = 1'b1;
               vec_d     = win1 ? VEC1 : VEC0;
            end else if (depth_d == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
      endcase
   end

   always_ff @(posedge CLK_i) begin
      if (Reset_i) begin
         state_q   <= ST_IDLE;
         cfg_q     <= '0;
         cur_q     <= '0;
         depth_q   <= '0;
         for (int k = 0; k < NEST_DEPTH; k++) stack_q[k] <= '0;
         src_q     <= 1'b0;
         req_lvl_q <= '0;
         int_q     <= 1'b0;
         vec_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         cur_q     <= cur_d;
         depth_q   <= depth_d;
         stack_q   <= stack_d;
         src_q     <= src_d;
         req_lvl_q <= req_lvl_d;
         int_q     <= int_d;
         vec_q     <= vec_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      intDataOut_o = '0;
      intDataOut_o[ST_CFG_LSB +: 6]   = {cfg_q.lvl1, cfg_q.lvl0, cfg_q.en1, cfg_q.en0};
      intDataOut_o[ST_PEND_LSB +: 2]  = {pend1, pend0};
      intDataOut_o[ST_CUR_LSB +: 2]   = cur_q;
      intDataOut_o[ST_DEPTH_LSB +: 2] = depth_q;
      intDataOut_o[ST_REQ_BIT]        = (state_q == ST_REQ);
      intDataOut_o[ST_ERR_BIT]        = err_q;
      intDataOut_o[ST_GIE_BIT]        = cfg_q.gie;
   end

   assign int_o       = int_q;
   assign intVector_o = vec_q;
   assign intLvl_o    = cur_q;

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
- Interrupt controller that sequences the datapath's interrupt entry and return for two external sources, `int0` and `int1`.
- Captures rising edges as pending requests and holds per-source priority levels programmed by a config write.
- Arbitrates pending sources against the currently running level and drives `int` plus a handler vector to the datapath.
- Tracks nested handlers on a small level stack, popped on return-from-interrupt.

Parameters:
- VEC0, 16'h0010, handler address for source 0
- VEC1, 16'h0020, handler address for source 1
- NEST_DEPTH, 2, maximum nested handlers (level stack entries)

Ports:
- CLK  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- int0  in  1  source 0 request line, rising-edge captured
- int1  in  1  source 1 request line, rising-edge captured
- intWrite  in  1  config write strobe
- intDataIn  in  16  config word: [0] en0, [1] en1, [3:2] lvl0, [5:4] lvl1, [15] gie
- intAck  in  1  datapath has taken the request (vectoring this cycle)
- intRet  in  1  datapath executed return-from-interrupt
- int  out  1  registered interrupt request to datapath
- intVector  out  16  handler address for the latched source; valid while int=1
- intLvl  out  2  current running level (0 = base code)
- intDataOut  out  16  status: [5:0] config, [7:6] pending{1,0}, [9:8] curLvl, [11:10] stack depth, [12] REQ state, [13] err, [15] gie

Behaviour:
- Reset effects (synchronous, active-high): int=0, intVector=0, curLvl=0, config=0, gie=0, pending=0, depth=0, err=0, state IDLE.
- Reset forces the previous-sample registers to 1, so a line held high through reset does not create a request.
- Reset mid-request or mid-service abandons everything.
- Edge capture:
  - pendingN sets on the edge where intN=1 and the previous sample was 0.
  - pendingN clears on intAck for source N.
  - If set and clear hit the same edge, set wins.
- Config write: intWrite=1 loads config on the edge. Pending bits are unaffected.
- Eligibility: a source is eligible when enN=1, pendingN=1, lvlN > curLvl, gie=1 and depth < NEST_DEPTH. A level of 0 therefore masks the source.
- Arbitration: the highest lvl wins; ties go to source 0.
- State machine:
  - IDLE/ACTIVE -> REQ: on the edge where any source is eligible. Latch src/lvl, set int=1, intVector=VECsrc.
  - Latency: a line rising before edge E1 sets pending at E1; int=1 after E2.
  - REQ holds int, intVector and the latched source stable until intAck. There is no re-arbitration and no withdrawal, even if the config changes.
  - REQ + intAck: push curLvl, set curLvl=latched lvl, depth+1, clear that source's pending, set int=0 on the same edge, go to ACTIVE.
  - ACTIVE + intRet: pop curLvl, depth-1. Go to IDLE when depth reaches 0.
  - REQ + intRet with depth>0: pop first. The request stays latched.
  - REQ with intAck and intRet on the same edge: pop, then push.
- Errors and ignored inputs:
  - intRet at depth 0 is ignored and sets err, which is sticky until Reset.
  - intAck outside REQ is ignored.
- Stack full (depth=NEST_DEPTH): no new REQ is issued. Pending bits are still accumulated.
- Outputs: intDataOut and intLvl are combinational from registers. int is registered.

Decomposition:
- Package intr_pkg holds:
  - the state enum IDLE/REQ/ACTIVE
  - config field positions (EN0, EN1, LVL0, LVL1, GIE)
  - status field positions
  - the 2-bit level type
- Sub-module intr_edge_pending: per-source previous-sample register plus pending flag with set-wins clear. It is instantiated twice.

Test Plan:
- Single request: write 16'h8005 (en0, lvl0=1, gie); pulse int0 -> pending0 at E1; int=1 and intVector=16'h0010 after E2; intAck -> intLvl=1, int=0.
- Priority and tie:
  - Write 16'h8037 (lvl0=1, lvl1=3); raise int0 and int1 together -> intVector=16'h0020, intLvl=3 after ack.
  - Rewrite both levels to 2 and repeat -> source 0 wins.
- Nesting: lvl0=1, lvl1=2; service int0, then raise int1 -> second REQ, ack -> depth=2, intLvl=2; two intRet -> intLvl 1 then 0, state IDLE.
- Masking and stack-full:
  - Equal or lower level does not interrupt; pending0 stays visible in intDataOut[6].
  - With depth=2, a third eligible edge raises no int until one intRet.
- Boundaries:
  - intRet in IDLE sets intDataOut[13]=1.
  - An int0 edge coincident with intAck for source 0 leaves pending0=1.
  - Reset during REQ -> int=0, intDataOut=0 the next cycle.
